prn_checker: RTL and testbench
==============================

# prn_checker

Receive-side checker for the pseudo-random sequence produced by the team's Galois LFSR generator. It takes the generator's parallel output words, self-synchronises to the sequence by seeding from the received data, and verifies each following word against a locally stepped copy. It reports lock status and keeps saturating error and word counters. It sits at the far end of any link or datapath under PRBS test.

## Interface
- `WIDTH`, 16: LFSR/word width; must be ≥ 7.
- `LOCK_COUNT`, 4: consecutive matching words needed after seeding to declare lock; must be ≥ 1.
- `LOSS_COUNT`, 4: consecutive mismatching words in LOCKED that drop lock; must be ≥ 1.
- `CNT_WIDTH`, 32: width of every statistics counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `chk_enable`  in  1  checker enable; when low, all state holds and `prn_valid` is ignored.
- `prn_valid`  in  1  `prn_in` carries a word this cycle.
- `prn_in`  in  WIDTH  received sequence word.
- `clear_cnt`  in  1  synchronous clear of all counters.
- `locked`  out  1  high while in LOCKED.
- `state`  out  2  HUNT=0, VERIFY=1, LOCKED=2.
- `err_pulse`  out  1  one-cycle flag for each mismatching word in LOCKED.
- `words_checked`  out  CNT_WIDTH  words compared while LOCKED.
- `word_err_cnt`  out  CNT_WIDTH  mismatching words while LOCKED.
- `bit_err_cnt`  out  CNT_WIDTH  mismatching bits while LOCKED; present only with `PRN_CHK_BIT_ERR_EN`.

## Operation
- Step function `step(x)` must match the generator exactly. For m = x[WIDTH-1]:
  - next = {x[WIDTH-2:5], x[4]^m, x[3], x[2]^m, x[1]^m, x[0], m}
  - Equivalent polynomial for WIDTH=16: x^16+x^5+x^3+x^2+1.
- A word is accepted when `chk_enable & prn_valid`. Nothing changes on cycles with no accepted word.
- Internal registers:
  - `exp` (WIDTH): expected next word.
  - `run`: consecutive-match count.
  - `miss`: consecutive-mismatch count.
- HUNT, on each accepted word:
  - `prn_in` ≠ 0: `exp` ← step(`prn_in`), `run` ← 0, go to VERIFY.
  - `prn_in` = 0 (LFSR lock-up value): rejected; stay in HUNT.
- VERIFY, on each accepted word:
  - `prn_in` = `exp`: `exp` ← step(`exp`), `run`++. Go to LOCKED when `run`+1 = LOCK_COUNT; on that transition `miss` ← 0.
  - Mismatch with `prn_in` ≠ 0: reseed, `exp` ← step(`prn_in`), `run` ← 0, stay in VERIFY.
  - Mismatch with `prn_in` = 0: go to HUNT.
- LOCKED (flywheel; never reseeds), on each accepted word:
  - Always: `exp` ← step(`exp`), `words_checked`++.
  - Match: `miss` ← 0.
  - Mismatch: `word_err_cnt`++, `bit_err_cnt` += popcount(`prn_in` ^ `exp`), `err_pulse` asserted, `miss`++. When `miss`+1 = LOSS_COUNT, go to HUNT; that final mismatch is still counted.
- Counters:
  - Count only in LOCKED.
  - Saturate at all-ones; `bit_err_cnt` clamps rather than wraps.
  - `clear_cnt` zeroes all counters and beats a same-cycle increment; that increment is lost. `clear_cnt` does not affect state, `exp` or `locked`.
- Reset (async assert, sync release): state=HUNT, `exp`=all ones, `run`=`miss`=0, all counters 0, `locked`=0, `err_pulse`=0.

## Timing
- All outputs are registered and update on the edge that samples the accepted word.
- `err_pulse` is high for exactly the one cycle after the mismatching word's sampling edge.
- Lock latency: `locked` rises after the (LOCK_COUNT+1)-th accepted word (one seed plus LOCK_COUNT matches). The word that causes lock is not counted in `words_checked`.
- Loss latency: `locked` falls on the edge that samples the LOSS_COUNT-th consecutive mismatch.
- Gaps in `prn_valid` or `chk_enable` stretch all latencies; lock is not lost during gaps.

## Configuration
- `PRN_CHK_BIT_ERR_EN` defined:
  - The popcount datapath and the `bit_err_cnt` port exist.
- `PRN_CHK_BIT_ERR_EN` undefined:
  - The port and logic are removed.
  - All other behaviour is identical.

## Test plan
- Lock from generator reset, WIDTH=16: feed FFFF, FFD3, then successive steps, 5 words in total. `locked`=1 after word 5; all counters 0; `words_checked` then increments once per word.
- Single error in LOCKED: one word XOR 0x0001. Response: one-cycle `err_pulse`, `word_err_cnt`=1, `bit_err_cnt`=1, lock kept, next clean word matches.
- Loss of lock: 4 consecutive words XOR 0x8000. Response: `word_err_cnt`=4, `bit_err_cnt`=4, `locked`=0 after 4th word, state=HUNT; a clean stream re-locks after 5 more words.
- Lock-up rejection: stream of 0x0000 words. Response: state stays HUNT; counters stay 0.
- Clear priority: assert `clear_cnt` on the cycle a mismatching word is accepted. Response: `word_err_cnt`=0 next cycle, `err_pulse` still 1.
- Reset and gaps:
  - While locked, hold `chk_enable`=0 and randomise `prn_in`: nothing changes.
  - Assert `reset` low mid-stream: all outputs 0 and state=HUNT immediately, without a clock edge.

Source files
------------

// File: rtl/prn_checker.sv
// PRBS receive checker: self-seeds from the incoming Galois LFSR stream, verifies each
// following word and keeps saturating statistics. Define PRN_CHK_BIT_ERR_EN for bit_err_cnt.
module prn_checker #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chk_enable,
    input  logic                 prn_valid,
    input  logic [WIDTH-1:0]     prn_in,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic [1:0]           state,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] words_checked,
`ifdef PRN_CHK_BIT_ERR_EN
    output logic [CNT_WIDTH-1:0] bit_err_cnt,
`endif
    output logic [CNT_WIDTH-1:0] word_err_cnt
);

    localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW = $clog2(LOSS_COUNT + 1);
    localparam logic [RunW-1:0]  LockLast = RunW'(LOCK_COUNT - 1);
    localparam logic [MissW-1:0] MissLast = MissW'(LOSS_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    // Must stay bit-identical to the generator's step.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        logic m;
        m = x[WIDTH-1];
        return {x[WIDTH-2:5], x[4] ^ m, x[3], x[2] ^ m, x[1] ^ m, x[0], m};
    endfunction

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [RunW-1:0]      run_q, run_d;
    logic [MissW-1:0]     miss_q, miss_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] words_checked_q, words_checked_d;
    logic [CNT_WIDTH-1:0] word_err_cnt_q, word_err_cnt_d;

    logic accept;
    logic in_zero;
    logic in_match;
    logic wc_inc;
    logic we_inc;

    assign accept   = chk_enable & prn_valid;
    assign in_zero  = (prn_in == '0);
    assign in_match = (prn_in == exp_q);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        wc_inc      = 1'b0;
        we_inc      = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (accept && !in_zero) begin
                    exp_d   = step(prn_in);
                    run_d   = '0;
                    state_d = StVerify;
                end
            end
            StVerify: begin
                if (accept) begin
                    if (in_match) begin
                        exp_d = step(exp_q);
                        run_d = run_q + RunW'(1);
                        if (run_q == LockLast) begin
                            miss_d  = '0;
                            state_d = StLocked;
                        end
                    end else if (!in_zero) begin
                        exp_d = step(prn_in);
                        run_d = '0;
                    end else begin
                        state_d = StHunt;
                    end
                end
            end
            StLocked: begin
                // Flywheel: the local copy keeps stepping even on mismatches.
                if (accept) begin
                    exp_d  = step(exp_q);
                    wc_inc = 1'b1;
                    if (in_match) begin
                        miss_d = '0;
                    end else begin
                        we_inc      = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_d      = miss_q + MissW'(1);
                        if (miss_q == MissLast) begin
                            state_d = StHunt;
                        end
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase

        locked_d = (state_d == StLocked);
    end

    always_comb begin
        words_checked_d = words_checked_q;
        word_err_cnt_d  = word_err_cnt_q;
        if (clear_cnt) begin
            words_checked_d = '0;
            word_err_cnt_d  = '0;
        end else begin
            if (wc_inc && (words_checked_q != CntMax)) begin
                words_checked_d = words_checked_q + CNT_WIDTH'(1);
            end
            if (we_inc && (word_err_cnt_q != CntMax)) begin
                word_err_cnt_d = word_err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PRN_CHK_BIT_ERR_EN
    localparam int unsigned PopW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]     diff;
    logic [PopW-1:0]      diff_pop;
    logic [CNT_WIDTH:0]   bit_sum;
    logic [CNT_WIDTH-1:0] bit_err_cnt_q, bit_err_cnt_d;

    assign diff = prn_in ^ exp_q;

    always_comb begin
        diff_pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            diff_pop = diff_pop + PopW'(diff[i]);
        end
    end

    // One extra bit catches the carry so the add clamps instead of wrapping.
    assign bit_sum = {1'b0, bit_err_cnt_q} + (CNT_WIDTH + 1)'(diff_pop);

    always_comb begin
        bit_err_cnt_d = bit_err_cnt_q;
        if (clear_cnt) begin
            bit_err_cnt_d = '0;
        end else if (we_inc) begin
            bit_err_cnt_d = bit_sum[CNT_WIDTH] ? CntMax : bit_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign bit_err_cnt = bit_err_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StHunt;
            exp_q           <= '1;
            run_q           <= '0;
            miss_q          <= '0;
            locked_q        <= 1'b0;
            err_pulse_q     <= 1'b0;
            words_checked_q <= '0;
            word_err_cnt_q  <= '0;
        end else begin
            state_q         <= state_d;
            exp_q           <= exp_d;
            run_q           <= run_d;
            miss_q          <= miss_d;
            locked_q        <= locked_d;
            err_pulse_q     <= err_pulse_d;
            words_checked_q <= words_checked_d;
            word_err_cnt_q  <= word_err_cnt_d;
        end
    end

    assign state         = state_q;
    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign words_checked = words_checked_q;
    assign word_err_cnt  = word_err_cnt_q;

endmodule

// File: tb/tb_prn_checker.sv
// Directed bench for prn_checker at default parameters (WIDTH=16, LOCK/LOSS_COUNT=4).
module tb_prn_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chk_enable = 1'b1;
    logic        prn_valid = 1'b0;
    logic [15:0] prn_in = '0;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic [1:0]  state;
    logic        err_pulse;
    logic [31:0] words_checked;
    logic [31:0] word_err_cnt;
`ifdef PRN_CHK_BIT_ERR_EN
    logic [31:0] bit_err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] g;

    always #5 clk = ~clk;

    prn_checker dut (
        .clk          (clk),
        .reset        (reset),
        .chk_enable   (chk_enable),
        .prn_valid    (prn_valid),
        .prn_in       (prn_in),
        .clear_cnt    (clear_cnt),
        .locked       (locked),
        .state        (state),
        .err_pulse    (err_pulse),
        .words_checked(words_checked),
`ifdef PRN_CHK_BIT_ERR_EN
        .bit_err_cnt  (bit_err_cnt),
`endif
        .word_err_cnt (word_err_cnt)
    );

    // Shift-and-xor form of x^16+x^5+x^3+x^2+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], 1'b0} ^ (x[15] ? 16'h002D : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic feed(input logic [15:0] w);
        prn_valid = 1'b1;
        prn_in    = w;
        @(posedge clk);
        #1;
        prn_valid = 1'b0;
    endtask

    // Feeds the next generator word with an error mask and advances the model.
    task automatic feed_gen(input logic [15:0] mask);
        feed(g ^ mask);
        g = lfsr_next(g);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] lock_seq [5];

    initial begin
        lock_seq[0] = 16'hFFFF;
        lock_seq[1] = 16'hFFD3;
        lock_seq[2] = 16'hFF8B;
        lock_seq[3] = 16'hFF3B;
        lock_seq[4] = 16'hFE5B;

        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_words", words_checked, 32'd0);
        check("rst_werr", word_err_cnt, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Lock-up value must never seed.
        for (int i = 0; i < 3; i++) feed(16'h0000);
        check("zero_hunt", 32'(state), 32'd0);
        check("zero_werr", word_err_cnt, 32'd0);

        // Lock from generator reset.
        for (int i = 0; i < 5; i++) begin
            feed(lock_seq[i]);
            if (i == 0) check("seed_verify", 32'(state), 32'd1);
            if (i == 3) check("lock_not_yet", 32'(locked), 32'd0);
        end
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_state", 32'(state), 32'd2);
        check("lock_words", words_checked, 32'd0);
        check("lock_werr", word_err_cnt, 32'd0);
        g = 16'hFC9B;
        for (int i = 0; i < 3; i++) feed_gen(16'h0000);
        check("clean_words", words_checked, 32'd3);
        check("clean_err_pulse", 32'(err_pulse), 32'd0);

        // Single-bit error.
        feed_gen(16'h0001);
        check("sbe_pulse", 32'(err_pulse), 32'd1);
        check("sbe_werr", word_err_cnt, 32'd1);
        check("sbe_locked", 32'(locked), 32'd1);
`ifdef PRN_CHK_BIT_ERR_EN
        check("sbe_bits", bit_err_cnt, 32'd1);
`endif
        idle();
        check("sbe_pulse_drop", 32'(err_pulse), 32'd0);
        feed_gen(16'h0000);
        check("sbe_next_werr", word_err_cnt, 32'd1);
        check("sbe_next_words", words_checked, 32'd5);

        // Enable gap with garbage on the bus.
        chk_enable = 1'b0;
        prn_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            prn_in = 16'($urandom);
            @(posedge clk);
            #1;
        end
        prn_valid  = 1'b0;
        chk_enable = 1'b1;
        check("gap_words", words_checked, 32'd5);
        check("gap_werr", word_err_cnt, 32'd1);
        check("gap_locked", 32'(locked), 32'd1);
        feed_gen(16'h0000);
        check("gap_resume_werr", word_err_cnt, 32'd1);
        check("gap_resume_words", words_checked, 32'd6);

        // Clear beats a same-cycle increment.
        clear_cnt = 1'b1;
        feed_gen(16'h0001);
        clear_cnt = 1'b0;
        check("clr_werr", word_err_cnt, 32'd0);
        check("clr_words", words_checked, 32'd0);
        check("clr_pulse", 32'(err_pulse), 32'd1);
        check("clr_locked", 32'(locked), 32'd1);
`ifdef PRN_CHK_BIT_ERR_EN
        check("clr_bits", bit_err_cnt, 32'd0);
`endif
        feed_gen(16'h0000);

        // Loss of lock after four consecutive MSB errors.
        for (int i = 0; i < 4; i++) begin
            feed_gen(16'h8000);
            if (i == 2) check("loss_not_yet", 32'(locked), 32'd1);
        end
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_state", 32'(state), 32'd0);
        check("loss_werr", word_err_cnt, 32'd4);
        check("loss_words", words_checked, 32'd5);
`ifdef PRN_CHK_BIT_ERR_EN
        check("loss_bits", bit_err_cnt, 32'd4);
`endif

        // Re-lock on a clean stream.
        for (int i = 0; i < 5; i++) begin
            feed_gen(16'h0000);
            if (i == 3) check("relock_not_yet", 32'(locked), 32'd0);
        end
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_werr", word_err_cnt, 32'd4);
        check("relock_words", words_checked, 32'd5);

        // Asynchronous reset mid-cycle with a pulse pending.
        feed_gen(16'h0100);
        check("pre_rst_pulse", 32'(err_pulse), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_pulse", 32'(err_pulse), 32'd0);
        check("arst_werr", word_err_cnt, 32'd0);
        check("arst_words", words_checked, 32'd0);
`ifdef PRN_CHK_BIT_ERR_EN
        check("arst_bits", bit_err_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
